// File: rtl/fir_mac_q15_if.sv
// fir_mac_q15_if: sample, result and coefficient-load ports
// of the time-multiplexed Q15 FIR filter.
interface fir_mac_q15_if #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int NTAPS  = 9
);
   localparam int AW = $clog2(NTAPS);

   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] data_in;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] filtered_output;
   logic                     sat;
   logic                     coef_we;
   logic [AW-1:0]            coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic                     coef_ready;

   modport master (
      output in_valid, data_in, out_ready,
      output coef_we, coef_addr, coef_data,
      input  in_ready, out_valid, filtered_output,
      input  sat, coef_ready
   );

   modport slave (
      input  in_valid, data_in, out_ready,
      input  coef_we, coef_addr, coef_data,
      output in_ready, out_valid, filtered_output,
      output sat, coef_ready
   );
endinterface

// File: rtl/fir_mac_q15.sv
// fir_mac_q15: coefficient-programmable Q15 FIR, one tap per clock
// through a single MAC, with half-up rounding and output saturation.
module fir_mac_q15 #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int NTAPS  = 9,
   parameter int FRAC   = 15,
   parameter int ACC_W  = 40
) (
   input  logic         clk,
   input  logic         reset,
   fir_mac_q15_if.slave bus
);
   localparam int AW  = $clog2(NTAPS);
   localparam int PW  = DATA_W + COEF_W;
   localparam int MID = (NTAPS - 1) / 2;

   localparam logic signed [COEF_W-1:0] C_UNITY =
      {1'b0, {(COEF_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OMAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OMIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] HALF =
      {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
   localparam logic signed [DATA_W-1:0] YMAX =
      {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] YMIN =
      {1'b1, {(DATA_W-1){1'b0}}};

   if (NTAPS < 2 || NTAPS > 64) begin : g_ntaps_chk
      $error("fir_mac_q15: NTAPS must be 2..64");
   end
   if (ACC_W < PW + AW) begin : g_acc_chk
      $error("fir_mac_q15: ACC_W too narrow for NTAPS");
   end

   typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

   state_t                   state_q, state_d;
   logic signed [DATA_W-1:0] x_q [NTAPS];
   logic signed [DATA_W-1:0] x_d [NTAPS];
   logic signed [COEF_W-1:0] c_q [NTAPS];
   logic signed [COEF_W-1:0] c_d [NTAPS];
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [AW-1:0]            k_q, k_d;
   logic signed [DATA_W-1:0] y_q, y_d;
   logic                     sat_q, sat_d;
   logic                     ov_q, ov_d;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  rnd;
   logic                     idle;

   assign idle = (state_q == IDLE);
   assign prod = PW'(c_q[k_q]) * PW'(x_q[k_q]);
   assign rnd  = (acc_q + HALF) >>> FRAC;

   assign bus.in_ready        = idle;
   assign bus.coef_ready      = idle;
   assign bus.out_valid       = ov_q;
   assign bus.filtered_output = y_q;
   assign bus.sat             = sat_q;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      c_d     = c_q;
      acc_d   = acc_q;
      k_d     = k_q;
      y_d     = y_q;
      sat_d   = sat_q;
      ov_d    = ov_q;
      // out-of-range addresses match no tap and are dropped
      if (bus.coef_we && idle) begin
         for (int k = 0; k < NTAPS; k++) begin
            if (int'(bus.coef_addr) == k) c_d[k] = bus.coef_data;
         end
      end
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               x_d[0] = bus.data_in;
               for (int k = 1; k < NTAPS; k++) x_d[k] = x_q[k-1];
               acc_d   = '0;
               k_d     = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = acc_q + ACC_W'(prod);
            k_d   = k_q + AW'(1);
            if (k_q == AW'(NTAPS - 1)) state_d = ROUND;
         end
         ROUND: begin
            if (rnd > OMAX) begin
               y_d   = YMAX;
               sat_d = 1'b1;
            end else if (rnd < OMIN) begin
               y_d   = YMIN;
               sat_d = 1'b1;
            end else begin
               y_d   = rnd[DATA_W-1:0];
               sat_d = 1'b0;
            end
            ov_d    = 1'b1;
            state_d = OUT;
         end
         OUT: begin
            if (bus.out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         k_q     <= '0;
         y_q     <= '0;
         sat_q   <= 1'b0;
         ov_q    <= 1'b0;
         for (int k = 0; k < NTAPS; k++) begin
            x_q[k] <= '0;
            c_q[k] <= (k == MID) ? C_UNITY : '0;
         end
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         y_q     <= y_d;
         sat_q   <= sat_d;
         ov_q    <= ov_d;
         x_q     <= x_d;
         c_q     <= c_d;
      end
   end
endmodule
